// File: rtl/des_pkg.sv
// DES constants shared by the round engine: FSM encoding, shift schedule, PC-1/PC-2, E, P, S-boxes.
// The right-rotate schedule and rotator are compiled only when DES_DECRYPT_EN is defined.
package des_pkg;

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} des_state_e;

  localparam logic [1:0] ENC_SHIFT_TBL [0:15] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                                  2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
`ifdef DES_DECRYPT_EN
  localparam logic [1:0] DEC_SHIFT_TBL [0:15] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
                                                  2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
`endif

  // Permutation tables use DES bit numbering: entry n selects source bit n, bit 1 being the MSB.
  localparam logic [6:0] PC1_TBL [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4};

  localparam logic [5:0] PC2_TBL [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

  localparam logic [5:0] E_TBL [0:47] = '{
    6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
    6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13, 6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
    6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21, 6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
    6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1};

  localparam logic [5:0] P_TBL [0:31] = '{
    6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17, 6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
    6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,  6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25};

  // Each 64-bit word is one S-box row; column 0 is the most significant nibble.
  localparam logic [63:0] SBOX_TBL [0:7][0:3] = '{
    '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
    '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
    '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
    '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
    '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
    '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
    '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
    '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}};

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[26:0], x[27]};
      2'd2:    return {x[25:0], x[27:26]};
      default: return x;
    endcase
  endfunction

`ifdef DES_DECRYPT_EN
  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
    case (n)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction
`endif

  // Permutations shift the selected bits in MSB-first so the first table entry lands in bit 1.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] res;
    logic [5:0]  pos;
    res = 56'd0;
    for (int i = 0; i < 56; i++) begin
      pos = 6'(7'd64 - PC1_TBL[i]);
      res = {res[54:0], k[pos]};
    end
    return res;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] res;
    logic [5:0]  pos;
    res = 48'd0;
    for (int i = 0; i < 48; i++) begin
      pos = 6'd56 - PC2_TBL[i];
      res = {res[46:0], cd[pos]};
    end
    return res;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] r);
    logic [47:0] res;
    logic [4:0]  pos;
    res = 48'd0;
    for (int i = 0; i < 48; i++) begin
      pos = 5'(6'd32 - E_TBL[i]);
      res = {res[46:0], r[pos]};
    end
    return res;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] s);
    logic [31:0] res;
    logic [4:0]  pos;
    res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      pos = 5'(6'd32 - P_TBL[i]);
      res = {res[30:0], s[pos]};
    end
    return res;
  endfunction

endpackage

// File: rtl/des_f_func.sv
// Combinational DES round function f(R,K): E-expansion, key mix, S1..S8 substitution, P permutation.
module des_f_func
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);

  logic [47:0] mix_s;

  // Row comes from the outer bits of each 6-bit group, column from the inner four.
  function automatic logic [31:0] sbox_layer(input logic [47:0] x);
    logic [47:0] rest;
    logic [5:0]  six;
    logic [31:0] res;
    rest = x;
    res  = 32'd0;
    for (int b = 0; b < 8; b++) begin
      six  = rest[47:42];
      res  = {res[27:0], 4'(SBOX_TBL[b][{six[5], six[0]}] >> (6'd60 - {six[4:1], 2'b00}))};
      rest = {rest[41:0], 6'd0};
    end
    return res;
  endfunction

  assign mix_s = e_expand(r) ^ k;
  assign f     = p_perm(sbox_layer(mix_s));

endmodule

// File: rtl/des_round_core.sv
// Iterative 16-round DES Feistel engine with on-the-fly key schedule; bit 1 (DES numbering) is the MSB of each bus.
// Define DES_DECRYPT_EN to honour in_decrypt with the right-rotate key schedule; otherwise encrypt only.
module des_round_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_l,
  input  logic [31:0] in_r,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_l,
  output logic [31:0] out_r
);

  des_state_e  state_r, state_nxt_s;
  logic [4:0]  rnd_r;
  logic [3:0]  rnd_idx_s;
  logic [31:0] l_r, r_r, f_s;
  logic [27:0] c_r, d_r, c_nxt_s, d_nxt_s;
  logic [47:0] k_s;
`ifdef DES_DECRYPT_EN
  logic        dec_r;
`else
  logic        unused_decrypt_s;
  assign unused_decrypt_s = in_decrypt;
`endif

  assign rnd_idx_s = 4'(rnd_r - 5'd1);
  assign k_s       = pc2({c_nxt_s, d_nxt_s});

  des_f_func u_f_func (
    .r (r_r),
    .k (k_s),
    .f (f_s)
  );

  // Key-half rotation for the round currently indexed by rnd_r.
  always_comb begin
    c_nxt_s = c_r;
    d_nxt_s = d_r;
`ifdef DES_DECRYPT_EN
    if (dec_r) begin
      c_nxt_s = rotr28(c_r, DEC_SHIFT_TBL[rnd_idx_s]);
      d_nxt_s = rotr28(d_r, DEC_SHIFT_TBL[rnd_idx_s]);
    end else begin
      c_nxt_s = rotl28(c_r, ENC_SHIFT_TBL[rnd_idx_s]);
      d_nxt_s = rotl28(d_r, ENC_SHIFT_TBL[rnd_idx_s]);
    end
`else
    c_nxt_s = rotl28(c_r, ENC_SHIFT_TBL[rnd_idx_s]);
    d_nxt_s = rotl28(d_r, ENC_SHIFT_TBL[rnd_idx_s]);
`endif
  end

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (in_valid)          state_nxt_s = ROUND; else state_nxt_s = IDLE;
      ROUND:   if (rnd_r == 5'd16)    state_nxt_s = DONE;  else state_nxt_s = ROUND;
      DONE:    if (out_ready)         state_nxt_s = IDLE;  else state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // Block load at accept, then one Feistel round per clock; registers hold through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_r <= 5'd0;
      l_r   <= 32'd0;
      r_r   <= 32'd0;
      c_r   <= 28'd0;
      d_r   <= 28'd0;
`ifdef DES_DECRYPT_EN
      dec_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            l_r        <= in_l;
            r_r        <= in_r;
            {c_r, d_r} <= pc1(in_key);
            rnd_r      <= 5'd1;
`ifdef DES_DECRYPT_EN
            dec_r      <= in_decrypt;
`endif
          end
        end
        ROUND: begin
          l_r <= r_r;
          r_r <= l_r ^ f_s;
          c_r <= c_nxt_s;
          d_r <= d_nxt_s;
          if (rnd_r != 5'd16) rnd_r <= rnd_r + 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign out_l     = r_r;
  assign out_r     = l_r;

endmodule

// File: tb/tb_des_round_core.sv
// Self-checking bench for des_round_core: known DES vectors plus randomized blocks against a textbook DES model.
module tb_des_round_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready;
  logic [31:0] in_l, in_r, out_l, out_r;
  logic [63:0] in_key;
  int          errors = 0;
  int          checks = 0;

`ifdef DES_DECRYPT_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  localparam logic [63:0] VKEY = 64'h133457799BBCDFF1;

  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                                41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int E_T [48]   = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
                                16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32]   = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int SHIFT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] SB_T [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  des_round_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_l(in_l), .in_r(in_r), .in_key(in_key), .in_decrypt(in_decrypt),
    .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r)
  );

  always #5 clk = ~clk;

  // Textbook round function on DES-numbered bits.
  function automatic logic [31:0] fref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0]  six;
    logic [63:0] rowv;
    x = 48'd0;
    for (int i = 0; i < 48; i++) x = {x[46:0], r[32 - E_T[i]]};
    x = x ^ k;
    s = 32'd0;
    for (int b = 0; b < 8; b++) begin
      six  = x[47 - 6*b -: 6];
      rowv = SB_T[b*4 + int'({six[5], six[0]})];
      s    = {s[27:0], rowv[63 - 4*int'(six[4:1]) -: 4]};
    end
    p = 32'd0;
    for (int i = 0; i < 32; i++) p = {p[30:0], s[32 - P_T[i]]};
    return p;
  endfunction

  // Full key schedule up front; decryption simply walks the subkeys in reverse. Returns {R16, L16}.
  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [31:0] l0, input logic [31:0] r0,
                                            input logic dec);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [31:0] l, r, t;
    cd = 56'd0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], key[64 - PC1_T[i]]};
    c = cd[55:28];
    d = cd[27:0];
    for (int n = 0; n < 16; n++) begin
      for (int s = 0; s < SHIFT_T[n]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd    = {c, d};
      ks[n] = 48'd0;
      for (int i = 0; i < 48; i++) ks[n] = {ks[n][46:0], cd[56 - PC2_T[i]]};
    end
    l = l0;
    r = r0;
    for (int n = 0; n < 16; n++) begin
      t = r;
      r = l ^ fref(r, dec ? ks[15 - n] : ks[n]);
      l = t;
    end
    return {r, l};
  endfunction

  // Offer one block, scramble inputs during the rounds, collect the result and hand it off.
  task automatic do_block(input logic [63:0] key, input logic [31:0] l, input logic [31:0] r, input logic dec,
                          output logic [31:0] got_l, output logic [31:0] got_r, output int lat);
    int guard = 0;
    while (!in_ready && guard < 40) begin @(posedge clk); #1; guard++; end
    in_key = key; in_l = l; in_r = r; in_decrypt = dec; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_l = $urandom; in_r = $urandom; in_key = {$urandom, $urandom}; in_decrypt = ~dec;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    got_l = out_l; got_r = out_r;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_decrypt = 1'b0;
    in_l = 32'd0; in_r = 32'd0; in_key = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (out_l !== 32'd0)    begin errors++; $display("FAIL rst_out_l: got %h want 0", out_l); end
    checks++; if (out_r !== 32'd0)    begin errors++; $display("FAIL rst_out_r: got %h want 0", out_r); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_encrypt_vector;
    logic [31:0] gl, gr;
    int lat;
    do_block(VKEY, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, gl, gr, lat);
    checks++; if (lat !== 16)          begin errors++; $display("FAIL enc_latency: got %0d want 16", lat); end
    checks++; if (gl !== 32'h0A4CD995) begin errors++; $display("FAIL enc_out_l: got %h want 0a4cd995", gl); end
    checks++; if (gr !== 32'h43423234) begin errors++; $display("FAIL enc_out_r: got %h want 43423234", gr); end
  endtask

  task automatic test_decrypt_mode;
    logic [31:0] gl, gr, el, er;
    int lat;
`ifdef DES_DECRYPT_EN
    do_block(VKEY, 32'h0A4CD995, 32'h43423234, 1'b1, gl, gr, lat);
    el = 32'hCC00CCFF; er = 32'hF0AAF0AA;
`else
    do_block(VKEY, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b1, gl, gr, lat);
    el = 32'h0A4CD995; er = 32'h43423234;
`endif
    checks++; if (lat !== 16) begin errors++; $display("FAIL dec_latency: got %0d want 16", lat); end
    checks++; if (gl !== el)  begin errors++; $display("FAIL dec_out_l: got %h want %h", gl, el); end
    checks++; if (gr !== er)  begin errors++; $display("FAIL dec_out_r: got %h want %h", gr, er); end
  endtask

  task automatic test_random;
    logic [63:0] key, exp;
    logic [31:0] l, r, gl, gr;
    logic dec;
    int lat;
    for (int n = 0; n < 12; n++) begin
      key = {$urandom, $urandom}; l = $urandom; r = $urandom; dec = 1'($urandom_range(0, 1));
      exp = des_model(key, l, r, dec & DEC_EN);
      do_block(key, l, r, dec, gl, gr, lat);
      checks++; if (lat !== 16)         begin errors++; $display("FAIL rand%0d_latency: got %0d want 16", n, lat); end
      checks++; if (gl !== exp[63:32]) begin errors++; $display("FAIL rand%0d_out_l: got %h want %h", n, gl, exp[63:32]); end
      checks++; if (gr !== exp[31:0])  begin errors++; $display("FAIL rand%0d_out_r: got %h want %h", n, gr, exp[31:0]); end
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] key, exp;
    logic [31:0] l, r;
    int lat;
    key = {$urandom, $urandom}; l = $urandom; r = $urandom;
    exp = des_model(key, l, r, 1'b0);
    in_key = key; in_l = l; in_r = r; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (lat == 8) out_ready = 1'b0;
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL bp_latency: got %0d want 16", lat); end
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_l = $urandom; in_r = $urandom; in_key = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1)     begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL bp_hold_ready c%0d: got %b want 0", c, in_ready); end
      checks++; if (out_l !== exp[63:32])   begin errors++; $display("FAIL bp_hold_l c%0d: got %h want %h", c, out_l, exp[63:32]); end
      checks++; if (out_r !== exp[31:0])    begin errors++; $display("FAIL bp_hold_r c%0d: got %h want %h", c, out_r, exp[31:0]); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] q_exp [$];
    logic [63:0] exp;
    int last_acc = -1;
    int results = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int cyc = 0; cyc < 90; cyc++) begin
      if (out_valid) begin
        results++;
        exp = (q_exp.size() > 0) ? q_exp.pop_front() : 64'd0;
        checks++;
        if ({out_l, out_r} !== exp) begin
          errors++; $display("FAIL b2b_result cyc%0d: got %h%h want %h", cyc, out_l, out_r, exp);
        end
      end
      in_l = $urandom; in_r = $urandom; in_key = {$urandom, $urandom}; in_decrypt = 1'($urandom_range(0, 1));
      if (in_ready) begin
        q_exp.push_back(des_model(in_key, in_l, in_r, in_decrypt & DEC_EN));
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc !== 18) begin
            errors++; $display("FAIL b2b_spacing cyc%0d: got %0d want 18", cyc, cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (results !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", results); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] key, exp;
    logic [31:0] l, r, gl, gr;
    int lat;
    in_key = {$urandom, $urandom}; in_l = $urandom; in_r = $urandom; in_decrypt = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready: got %b want 1", in_ready); end
    checks++; if (out_l !== 32'd0)    begin errors++; $display("FAIL mid_rst_out_l: got %h want 0", out_l); end
    checks++; if (out_r !== 32'd0)    begin errors++; $display("FAIL mid_rst_out_r: got %h want 0", out_r); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    key = {$urandom, $urandom}; l = $urandom; r = $urandom;
    exp = des_model(key, l, r, 1'b0);
    do_block(key, l, r, 1'b0, gl, gr, lat);
    checks++; if (lat !== 16)         begin errors++; $display("FAIL post_rst_latency: got %0d want 16", lat); end
    checks++; if (gl !== exp[63:32]) begin errors++; $display("FAIL post_rst_out_l: got %h want %h", gl, exp[63:32]); end
    checks++; if (gr !== exp[31:0])  begin errors++; $display("FAIL post_rst_out_r: got %h want %h", gr, exp[31:0]); end
  endtask

  initial begin
    test_reset();
    test_encrypt_vector();
    test_decrypt_mode();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
